uart_write_arbiter: RTL and testbench

Round-robin packet arbiter that shares the UART transmit path among `NUM_REQ` byte-stream requesters. It sits in front of the UART controller's write FIFO and grants exclusive access for one burst at a time, so bytes from different requesters never interleave. It ends a burst on an explicit last byte, on a length cap, or on an idle timeout. Output bytes are registered and paced so that the FIFO's `write_ready` is never stale.

---
 rtl/uart_write_arbiter_if.sv | 26 ++
 rtl/uart_write_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_write_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_write_arbiter_if.sv
// Byte-stream bundle between the requesters, the UART write arbiter
// and the UART write FIFO.
interface uart_write_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   grant;
    logic [8*NUM_REQ-1:0] data_in;
    logic [NUM_REQ-1:0]   data_in_valid;
    logic [NUM_REQ-1:0]   data_in_last;
    logic [NUM_REQ-1:0]   data_in_ready;
    logic                 write_ready;
    logic [7:0]           data_out;
    logic                 data_out_valid;
    logic                 busy;

    modport master (
        output req, data_in, data_in_valid, data_in_last, write_ready,
        input  grant, data_in_ready, data_out, data_out_valid, busy
    );

    modport slave (
        input  req, data_in, data_in_valid, data_in_last, write_ready,
        output grant, data_in_ready, data_out, data_out_valid, busy
    );
endinterface

// File: rtl/uart_write_arbiter.sv
// Round-robin burst arbiter in front of the UART write FIFO.
// Define UART_WRITE_ARBITER_FRAME_EN to prefix each grant with {4'hA, g}.
module uart_write_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic                 clock,
    input logic                 reset,
    uart_write_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, HEADER, BURST, GAP} state_t;

    state_t             state;
    state_t             ret;
    logic [NUM_REQ-1:0] grant;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      pick;
    logic [IW-1:0]      nxt_ptr;
    logic [CW-1:0]      byte_cnt;
    logic [TW-1:0]      idle_cnt;
    logic [7:0]         data_out;
    logic               data_out_valid;
    logic [SW-1:0]      scan;
    logic               found;
    logic [7:0]         lane_data;
    logic               lane_valid;
    logic               lane_last;
    logic               lane_req;
    logic               cap_hit;
    logic               idle_hit;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        pick  = rr_ptr;
        found = 1'b0;
        scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NUM_REQ))
                scan = scan - SW'(NUM_REQ);
            if (!found && bus.req[scan[IW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IW-1:0];
            end
        end
    end

    assign nxt_ptr    = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign lane_data  = bus.data_in[{gidx, 3'b000} +: 8];
    assign lane_valid = bus.data_in_valid[gidx];
    assign lane_last  = bus.data_in_last[gidx];
    assign lane_req   = bus.req[gidx];
    assign cap_hit    = (byte_cnt == CW'(MAX_BURST - 1));
    assign idle_hit   = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign bus.grant          = grant;
    assign bus.data_in_ready  = (state == BURST && bus.write_ready) ? grant : '0;
    assign bus.data_out       = data_out;
    assign bus.data_out_valid = data_out_valid;
    assign bus.busy           = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ret            <= IDLE;
            grant          <= '0;
            gidx           <= '0;
            rr_ptr         <= '0;
            byte_cnt       <= '0;
            idle_cnt       <= '0;
            data_out       <= 8'h00;
            data_out_valid <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        gidx     <= pick;
                        grant    <= NUM_REQ'(1) << pick;
                        byte_cnt <= '0;
                        idle_cnt <= '0;
`ifdef UART_WRITE_ARBITER_FRAME_EN
                        state    <= HEADER;
`else
                        state    <= BURST;
`endif
                    end
                end
`ifdef UART_WRITE_ARBITER_FRAME_EN
                HEADER: begin
                    if (bus.write_ready) begin
                        data_out       <= {4'hA, 4'(gidx)};
                        data_out_valid <= 1'b1;
                        ret            <= BURST;
                        state          <= GAP;
                    end
                end
`endif
                BURST: begin
                    if (lane_valid && bus.write_ready) begin
                        data_out       <= lane_data;
                        data_out_valid <= 1'b1;
                        byte_cnt       <= byte_cnt + 1'b1;
                        idle_cnt       <= '0;
                        ret            <= (lane_last || cap_hit) ? IDLE : BURST;
                        state          <= GAP;
                    end else if (!lane_req || (!lane_valid && idle_hit)) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                        state  <= IDLE;
                    end else if (!lane_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // Release coincides with leaving GAP at the end of a burst.
                    state <= ret;
                    if (ret == IDLE) begin
                        grant  <= '0;
                        rr_ptr <= nxt_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_write_arbiter.sv
// Testbench for uart_write_arbiter: directed table, corner sequences,
// and random queued traffic against a burst-level reference model.
module tb_uart_write_arbiter;
    localparam int NR = 4;
    localparam int MB = 16;
    localparam int TO = 8;

`ifdef UART_WRITE_ARBITER_FRAME_EN
    localparam bit FRAME = 1'b1;
`else
    localparam bit FRAME = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;

    uart_write_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_write_arbiter #(
        .NUM_REQ(NR),
        .MAX_BURST(MB),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    typedef struct packed {
        logic [7:0] d;
        int         own;
    } out_t;

    typedef struct {
        logic [3:0] mask;
        logic [7:0] base;
        int         g;
        logic [7:0] exp_d;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   model_rr = 0;
    int   model_bursts = 0;
    ent_t lq[NR][$];
    ent_t cq[NR][$];
    out_t exq[$];
    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_err++;
        $display("FAIL %s: got bound expired or stray event, expected none", name);
    endtask

    task automatic clr_lanes();
        bus.req           = '0;
        bus.data_in_valid = '0;
        bus.data_in_last  = '0;
        bus.data_in       = '0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        clr_lanes();
        do begin
            @(negedge clock);
            n++;
        end while (bus.busy && n < 40);
        chk(name, 32'(bus.busy), 0);
    endtask

    function automatic bit pending();
        bit any;
        any = 1'b0;
        for (int i = 0; i < NR; i++)
            if (lq[i].size() > 0) any = 1'b1;
        return any;
    endfunction

    // Burst-level model: round-robin over non-empty lanes, a burst ends
    // on last, on MAX_BURST bytes, or when the lane runs dry.
    task automatic build_expected();
        int   p;
        int   g;
        int   n;
        bit   done;
        ent_t e;
        out_t o;
        for (int i = 0; i < NR; i++) cq[i] = lq[i];
        p = model_rr;
        model_bursts = 0;
        done = 1'b0;
        while (!done) begin
            g = -1;
            for (int k = 0; k < NR; k++)
                if (g < 0 && cq[(p + k) % NR].size() > 0) g = (p + k) % NR;
            if (g < 0) begin
                done = 1'b1;
            end else begin
                model_bursts++;
                if (FRAME) begin
                    o.d = {4'hA, 4'(g)};
                    o.own = g;
                    exq.push_back(o);
                end
                n = 0;
                do begin
                    e = cq[g].pop_front();
                    o.d = e.d;
                    o.own = g;
                    exq.push_back(o);
                    n++;
                end while (!e.l && n < MB && cq[g].size() > 0);
                p = (g + 1) % NR;
            end
        end
        model_rr = p;
    endtask

    task automatic run_engine(input int wr_pct, input int budget);
        int          cyc;
        int          rises;
        logic [NR-1:0] acc;
        logic [NR-1:0] gprev;
        bit          pdov;
        out_t        o;
        cyc = 0;
        rises = 0;
        gprev = '0;
        pdov = 1'b0;
        build_expected();
        while (cyc < budget && (exq.size() > 0 || pending() || bus.busy)) begin
            @(negedge clock);
            cyc++;
            if (bus.data_out_valid) begin
                chk("no_back_to_back", 32'(pdov), 0);
                if (exq.size() == 0) begin
                    fail("extra_byte");
                end else begin
                    o = exq.pop_front();
                    chk("out_byte", 32'(bus.data_out), 32'(o.d));
                    chk("out_owner", 32'(bus.grant), 32'(1) << o.own);
                end
            end
            pdov = bus.data_out_valid;
            if (gprev == '0 && bus.grant != '0) rises++;
            gprev = bus.grant;
            bus.write_ready = ($urandom_range(99) < wr_pct);
            for (int i = 0; i < NR; i++) begin
                if (lq[i].size() > 0) begin
                    bus.req[i]           = 1'b1;
                    bus.data_in_valid[i] = 1'b1;
                    bus.data_in_last[i]  = lq[i][0].l;
                    bus.data_in[8*i +: 8] = lq[i][0].d;
                end else begin
                    bus.req[i]           = 1'b0;
                    bus.data_in_valid[i] = 1'b0;
                    bus.data_in_last[i]  = 1'b0;
                    bus.data_in[8*i +: 8] = 8'h00;
                end
            end
            #1;
            acc = bus.data_in_valid & bus.data_in_ready;
            @(posedge clock);
            for (int i = 0; i < NR; i++)
                if (acc[i]) void'(lq[i].pop_front());
        end
        if (cyc >= budget) fail("engine_budget");
        chk("engine_drained", exq.size(), 0);
        chk("engine_bursts", rises, model_bursts);
        exq.delete();
        clr_lanes();
    endtask

    initial begin
        int   n;
        int   held;
        int   cnt;
        bit   done;
        ent_t e;

        tbl[0] = '{4'b1111, 8'h20, 0, 8'h20};
        tbl[1] = '{4'b1111, 8'h30, 1, 8'h31};
        tbl[2] = '{4'b1111, 8'h40, 2, 8'h42};
        tbl[3] = '{4'b1111, 8'h50, 3, 8'h53};
        tbl[4] = '{4'b1111, 8'h60, 0, 8'h60};
        tbl[5] = '{4'b0001, 8'h70, 0, 8'h70};
        tbl[6] = '{4'b1000, 8'h52, 3, 8'h55};
        tbl[7] = '{4'b0110, 8'h80, 1, 8'h81};
        tbl[8] = '{4'b0011, 8'h90, 0, 8'h90};
        tbl[9] = '{4'b1100, 8'hA0, 2, 8'hA2};

        clr_lanes();
        bus.write_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_ready", 32'(bus.data_in_ready), 0);
        chk("rst_data", 32'(bus.data_out), 0);
        chk("rst_valid", 32'(bus.data_out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        reset = 1'b1;
        @(negedge clock);

        // Single-byte bursts: round-robin order and lane selection.
        foreach (tbl[r]) begin
            clr_lanes();
            bus.write_ready = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (tbl[r].mask[i]) begin
                    bus.req[i]            = 1'b1;
                    bus.data_in_valid[i]  = 1'b1;
                    bus.data_in_last[i]   = 1'b1;
                    bus.data_in[8*i +: 8] = tbl[r].base + 8'(i);
                end
            end
            done = 1'b0;
`ifdef UART_WRITE_ARBITER_FRAME_EN
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (!bus.data_out_valid && n < 20);
            chk("tbl_header", 32'(bus.data_out), 32'({4'hA, 4'(tbl[r].g)}));
`endif
            n = 0;
            while (!done && n < 20) begin
                @(negedge clock);
                n++;
                if (bus.data_out_valid) begin
                    chk("tbl_grant", 32'(bus.grant), 32'(1) << tbl[r].g);
                    chk("tbl_byte", 32'(bus.data_out), 32'(tbl[r].exp_d));
                    clr_lanes();
                    done = 1'b1;
                end
            end
            if (!done) fail("tbl_no_byte");
            wait_idle("tbl_idle");
            model_rr = (tbl[r].g + 1) % NR;
        end

        // Length cap: 20 bytes without last split into 16 + 4.
        for (int b = 0; b < 20; b++) begin
            e.d = 8'hC0 + 8'(b);
            e.l = 1'b0;
            lq[2].push_back(e);
        end
        run_engine(100, 500);

        // Back-pressure: long write_ready stall, no timeout.
        clr_lanes();
        bus.write_ready        = 1'b0;
        bus.req[1]             = 1'b1;
        bus.data_in_valid[1]   = 1'b1;
        bus.data_in_last[1]    = 1'b1;
        bus.data_in[15:8]      = 8'h77;
        repeat (2) @(negedge clock);
        chk("bp_grant", 32'(bus.grant), 32'h2);
        cnt = 0;
        repeat (50) begin
            @(negedge clock);
            if (bus.data_out_valid) cnt++;
        end
        chk("bp_no_write", cnt, 0);
        chk("bp_grant_held", 32'(bus.grant), 32'h2);
        bus.write_ready = 1'b1;
        @(negedge clock);
        chk("bp_resume_valid", 32'(bus.data_out_valid), 1);
        chk("bp_resume_byte", 32'(bus.data_out), FRAME ? 32'hA1 : 32'h77);
`ifdef UART_WRITE_ARBITER_FRAME_EN
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.data_out_valid && n < 20);
        chk("bp_data_byte", 32'(bus.data_out), 32'h77);
`endif
        wait_idle("bp_idle");
        model_rr = 2;

        // Timeout: owner never sends; next requester follows one IDLE later.
        clr_lanes();
        bus.write_ready = 1'b1;
        bus.req = 4'b1001;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant == '0 && n < 5);
        chk("to_first_grant", 32'(bus.grant), 32'h8);
        held = 0;
        while (bus.grant == 4'b1000 && held < 40) begin
            held++;
            @(negedge clock);
        end
        chk("to_hold_cycles", held, FRAME ? 10 : 8);
        chk("to_idle_gap", 32'(bus.grant), 0);
        @(negedge clock);
        chk("to_next_grant", 32'(bus.grant), 32'h1);
        wait_idle("to_idle");
        model_rr = 1;

        // Asynchronous reset while a write strobe is in flight.
        clr_lanes();
        bus.write_ready      = 1'b1;
        bus.req[2]           = 1'b1;
        bus.data_in_valid[2] = 1'b1;
        bus.data_in[23:16]   = 8'h3C;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.data_out_valid && n < 20);
        chk("mid_valid_before", 32'(bus.data_out_valid), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(bus.grant), 0);
        chk("mid_rst_ready", 32'(bus.data_in_ready), 0);
        chk("mid_rst_data", 32'(bus.data_out), 0);
        chk("mid_rst_valid", 32'(bus.data_out_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        clr_lanes();
        @(negedge clock);
        reset = 1'b1;
        bus.req = 4'b1111;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (bus.grant == '0 && n < 5);
        chk("mid_first_grant", 32'(bus.grant), 32'h1);
        wait_idle("mid_idle");
        model_rr = 1;

        // Random queued packets with random FIFO back-pressure.
        repeat (3) begin
            for (int i = 0; i < NR; i++) begin
                n = $urandom_range(3);
                for (int p = 0; p < n; p++) begin
                    cnt = $urandom_range(20, 1);
                    for (int b = 0; b < cnt; b++) begin
                        e.d = 8'($urandom);
                        e.l = (b == cnt - 1);
                        lq[i].push_back(e);
                    end
                end
            end
            run_engine(70, 6000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
